// File: rtl/ctrl_pkg.sv
//============================================================================
// Module      : ctrl_pkg
// Description : Shared opcode and ALU codes, FSM state encoding and the
//               multiply counter type for the pico-MIPS control sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package ctrl_pkg;

    // Opcode field codes
    localparam logic [5:0] NOP  = 6'h00;
    localparam logic [5:0] ADD  = 6'h01;
    localparam logic [5:0] SUB  = 6'h02;
    localparam logic [5:0] ADDI = 6'h03;
    localparam logic [5:0] SUBI = 6'h04;
    localparam logic [5:0] MLT  = 6'h05;
    localparam logic [5:0] MLTI = 6'h06;
    localparam logic [5:0] LD   = 6'h07;
    localparam logic [5:0] ST   = 6'h08;
    localparam logic [5:0] JMP  = 6'h09;

    // ALU operation codes; RADD is zero so the idle output word is all zeros
    localparam logic [2:0] RADD = 3'd0;
    localparam logic [2:0] RSUB = 3'd1;
    localparam logic [2:0] RMLT = 3'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MUL      = 3'd4,
        IN_WAIT  = 3'd5,
        OUT_WAIT = 3'd6
    } state_t;

    typedef logic [3:0] mul_cnt_t;

    // True for every opcode the sequencer knows how to execute
    function automatic logic is_legal(input logic [5:0] op);
        return (op <= JMP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_mul_timer.sv
//============================================================================
// Module      : mul_timer
// Description : Loadable down-counter that flags when it has reached zero.
//               Used to time the multiply phase of the control sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mul_timer
    import ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  mul_cnt_t load_val,
    input  logic     en,
    output logic     done
);

    mul_cnt_t r_count;

    // Load has priority; otherwise count down while enabled, holding at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - mul_cnt_t'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
//============================================================================
// Module      : control_sequencer
// Description : Multi-cycle control FSM for the pico-MIPS core. Sequences
//               fetch, decode, execute, multiply wait and I/O handshakes,
//               with single-step debug support.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int MUL_CYCLES = 4
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ZF,
    input  logic                step_mode,
    input  logic                step,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic                ir_load,
    output logic                pc_en,
    output logic                pc_rel_branch,
    output logic [2:0]          alu_func,
    output logic                immediate,
    output logic                reg_write,
    output logic                read_in,
    output logic                in_ready,
    output logic                out_valid,
    output logic                write_out,
    output logic                illegal_op
);

    localparam mul_cnt_t C_MUL_LOAD = mul_cnt_t'(MUL_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_op_q;
    logic                w_mul_load;
    logic                w_mul_done;
    logic                w_unused;

    // Zero flag is reserved for future conditional branches
    assign w_unused = ZF;

    mul_timer u_mul_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_mul_load),
        .load_val (C_MUL_LOAD),
        .en       (r_state == MUL),
        .done     (w_mul_done)
    );

    // State register and opcode latch; illegal opcodes are latched as NOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_op_q  <= NOP;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_op_q <= is_legal(opcode) ? opcode : NOP;
            end
        end
    end

    // Next-state and output decode from the current state and latched opcode
    always_comb begin
        w_next        = r_state;
        w_mul_load    = 1'b0;
        ir_load       = 1'b0;
        pc_en         = 1'b0;
        pc_rel_branch = 1'b0;
        alu_func      = RADD;
        immediate     = 1'b0;
        reg_write     = 1'b0;
        read_in       = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        write_out     = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = FETCH;
            end
            FETCH: begin
                if (!step_mode || step) begin
                    ir_load = 1'b1;
                    w_next  = DECODE;
                end
            end
            DECODE: begin
                illegal_op = !is_legal(opcode);
                case (opcode)
                    MLT, MLTI: begin
                        w_next     = MUL;
                        w_mul_load = 1'b1;
                    end
                    LD:      w_next = IN_WAIT;
                    ST:      w_next = OUT_WAIT;
                    default: w_next = EXEC;
                endcase
            end
            EXEC: begin
                pc_en     = 1'b1;
                immediate = (r_op_q == ADDI) || (r_op_q == SUBI);
                case (r_op_q)
                    ADD, ADDI: reg_write = 1'b1;
                    SUB, SUBI: begin
                        alu_func  = RSUB;
                        reg_write = 1'b1;
                    end
                    JMP:       pc_rel_branch = 1'b1;
                    default:   ;
                endcase
                w_next = FETCH;
            end
            MUL: begin
                alu_func  = RMLT;
                immediate = (r_op_q == MLTI);
                if (w_mul_done) begin
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    w_next    = FETCH;
                end
            end
            IN_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    read_in   = 1'b1;
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    w_next    = FETCH;
                end
            end
            OUT_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    write_out = 1'b1;
                    pc_en     = 1'b1;
                    w_next    = FETCH;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. Builds the
//               expected per-cycle output trace of each instruction from
//               the instruction's class and compares it cycle by cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_control_sequencer;
    import ctrl_pkg::*;

    localparam int OPCODE_W   = 6;
    localparam int MUL_CYCLES = 4;

    // Per-cycle stimulus kinds
    localparam logic [2:0] K_FREE  = 3'd0;
    localparam logic [2:0] K_STALL = 3'd1;
    localparam logic [2:0] K_FETCH = 3'd2;
    localparam logic [2:0] K_INW   = 3'd3;
    localparam logic [2:0] K_INR   = 3'd4;
    localparam logic [2:0] K_OUTW  = 3'd5;
    localparam logic [2:0] K_OUTR  = 3'd6;

    typedef struct packed {
        logic [12:0] exp;
        logic [2:0]  kind;
    } cyc_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [OPCODE_W-1:0] opcode;
    logic                ZF, step_mode, step, in_valid, out_ready;
    logic                ir_load, pc_en, pc_rel_branch, immediate, reg_write;
    logic                read_in, in_ready, out_valid, write_out, illegal_op;
    logic [2:0]          alu_func;
    logic [12:0]         obs;

    int total = 0;
    int bad   = 0;

    control_sequencer #(.OPCODE_W(OPCODE_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .ZF(ZF),
        .step_mode(step_mode), .step(step), .in_valid(in_valid), .out_ready(out_ready),
        .ir_load(ir_load), .pc_en(pc_en), .pc_rel_branch(pc_rel_branch),
        .alu_func(alu_func), .immediate(immediate), .reg_write(reg_write),
        .read_in(read_in), .in_ready(in_ready), .out_valid(out_valid),
        .write_out(write_out), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {ir_load, pc_en, pc_rel_branch, alu_func, immediate, reg_write,
                  read_in, in_ready, out_valid, write_out, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Output word in the same bit order as obs
    function automatic logic [12:0] ov(input bit ir, input bit pc, input bit br,
                                       input logic [2:0] alu, input bit imm, input bit rw,
                                       input bit rd, input bit inr, input bit ovl,
                                       input bit wo, input bit ill);
        return {ir, pc, br, alu, imm, rw, rd, inr, ovl, wo, ill};
    endfunction

    // Build the instruction's expected trace, then drive and compare it
    task automatic run_instr(input string name, input logic [5:0] op, input bit smode,
                             input int stall, input int wait_n);
        cyc_t q[$];
        int   pcn = 0;
        int   dec_idx;
        bit   ill;
        ill = !(op inside {NOP, ADD, SUB, ADDI, SUBI, MLT, MLTI, LD, ST, JMP});
        if (smode) begin
            for (int i = 0; i < stall; i++) q.push_back({13'h0, K_STALL});
        end
        q.push_back({ov(1,0,0,RADD,0,0,0,0,0,0,0), K_FETCH});
        dec_idx = q.size();
        q.push_back({ov(0,0,0,RADD,0,0,0,0,0,0,ill), K_FREE});
        if (op == MLT || op == MLTI) begin
            for (int k = 0; k < MUL_CYCLES; k++) begin
                bit last;
                last = (k == MUL_CYCLES - 1);
                q.push_back({ov(0,last,0,RMLT,op == MLTI,last,0,0,0,0,0), K_FREE});
            end
        end else if (op == LD) begin
            for (int k = 0; k < wait_n; k++) q.push_back({ov(0,0,0,RADD,0,0,0,1,0,0,0), K_INW});
            q.push_back({ov(0,1,0,RADD,0,1,1,1,0,0,0), K_INR});
        end else if (op == ST) begin
            for (int k = 0; k < wait_n; k++) q.push_back({ov(0,0,0,RADD,0,0,0,0,1,0,0), K_OUTW});
            q.push_back({ov(0,1,0,RADD,0,0,0,0,1,1,0), K_OUTR});
        end else begin
            bit is_add, is_sub;
            is_add = (op == ADD) || (op == ADDI);
            is_sub = (op == SUB) || (op == SUBI);
            q.push_back({ov(0, 1, op == JMP, is_sub ? RSUB : RADD,
                            (op == ADDI) || (op == SUBI), is_add || is_sub,
                            0, 0, 0, 0, 0), K_FREE});
        end

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            step_mode = smode;
            opcode    = (i <= dec_idx) ? op : OPCODE_W'($urandom);
            ZF        = 1'($urandom);
            step      = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            case (q[i].kind)
                K_STALL: step = 1'b0;
                K_FETCH: if (smode) step = 1'b1;
                K_INW:   in_valid = 1'b0;
                K_INR:   in_valid = 1'b1;
                K_OUTW:  out_ready = 1'b0;
                K_OUTR:  out_ready = 1'b1;
                default: ;
            endcase
            #1;
            check($sformatf("%s[%0d]", name, i), 32'(obs), 32'(q[i].exp));
            pcn += int'(pc_en);
        end
        check({name, "_pc_once"}, pcn, 1);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = NOP;
        ZF        = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset_outputs", 32'(obs), 32'h0);
        repeat (2) @(negedge clk);
        check("reset_held", 32'(obs), 32'h0);
        reset = 1'b0;
        #1;
        check("idle_outputs", 32'(obs), 32'h0);

        // Directed cases
        run_instr("add",   ADD,   0, 0, 0);
        run_instr("mlti",  MLTI,  0, 0, 0);
        run_instr("ld5",   LD,    0, 0, 5);
        run_instr("st0",   ST,    0, 0, 0);
        run_instr("st3",   ST,    0, 0, 3);
        run_instr("jmp",   JMP,   0, 0, 0);
        run_instr("ill3f", 6'h3F, 0, 0, 0);
        run_instr("subi",  SUBI,  0, 0, 0);
        run_instr("step",  ADD,   1, 10, 0);
        run_instr("step2", MLT,   1, 3, 0);

        // Reset asserted during the second multiply cycle
        @(negedge clk);
        step_mode = 1'b0; opcode = MLT; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rmul_fetch", 32'(obs), 32'(ov(1,0,0,RADD,0,0,0,0,0,0,0)));
        @(negedge clk);
        #1;
        check("rmul_decode", 32'(obs), 32'h0);
        @(negedge clk);
        opcode = ADD;
        #1;
        check("rmul_mul1", 32'(obs), 32'(ov(0,0,0,RMLT,0,0,0,0,0,0,0)));
        @(negedge clk);
        #1;
        check("rmul_mul2", 32'(obs), 32'(ov(0,0,0,RMLT,0,0,0,0,0,0,0)));
        reset = 1'b1;
        #1;
        check("rmul_async", 32'(obs), 32'h0);
        @(negedge clk);
        #1;
        check("rmul_held", 32'(obs), 32'h0);
        reset = 1'b0;
        #1;
        check("rmul_idle", 32'(obs), 32'h0);
        run_instr("after_rst", MLTI, 0, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            int         sel;
            sel = int'($urandom_range(0, 11));
            if (sel <= 9)       op = 6'(sel);
            else if (sel == 10) op = 6'h3F;
            else                op = 6'($urandom_range(10, 62));
            run_instr($sformatf("rnd%0d", n), op, ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
